// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: loader states, memory geometry and
// the word-count legality check.
package boot_loader_pkg;

  localparam int WIDTH       = 16;
  localparam int DEPTH       = 8192;
  localparam int ADDR_WIDTH  = 13;
  localparam int MAX_WORDS   = DEPTH;
  localparam int COUNT_WIDTH = 14;

  typedef enum logic [3:0] {
    COUNT_LO,
    COUNT_HI,
    WORD_LO,
    WORD_HI,
    CHECK_LO,
    CHECK_HI,
    RELEASE,
    RUN,
    ERROR
  } state_t;

  function automatic logic count_is_legal(input logic [15:0] n);
    return (n != 16'd0) && (n <= 16'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/boot_loader_release_counter.sv
// Loadable down-counter that times how long the core stays held in reset
// after a good load.
module boot_loader_release_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 decrement,
  output logic                 last
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count <= CNT_WIDTH'(1));

endmodule

// File: rtl/boot_loader.sv
// Streams a little-endian image (count, words, XOR checksum) into instruction
// RAM, then releases the core from reset once the checksum matches.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  start,
  output logic                  instruction_write_enable,
  output logic [ADDR_WIDTH-1:0] instruction_write_address,
  output logic [WIDTH-1:0]      instruction_write_data,
  output logic                  core_active_low_reset,
  output logic                  load_done,
  output logic                  load_error
);

  state_t state, next_state;

  logic                   transfer;
  logic [7:0]             low_byte;
  logic [WIDTH-1:0]       rx_word;
  logic [COUNT_WIDTH-1:0] word_count;
  logic [COUNT_WIDTH-1:0] word_index;
  logic [WIDTH-1:0]       checksum;
  logic                   release_last;
  logic                   release_load;

  assign transfer     = byte_valid && byte_ready;
  assign rx_word      = {byte_data, low_byte};
  assign release_load = (state == CHECK_HI) && (next_state == RELEASE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= COUNT_LO;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      COUNT_LO: if (transfer) next_state = COUNT_HI;
      COUNT_HI: if (transfer) next_state = count_is_legal(rx_word) ? WORD_LO : ERROR;
      WORD_LO:  if (transfer) next_state = WORD_HI;
      WORD_HI:  if (transfer)
                  next_state = (word_index == word_count - 1'b1) ? CHECK_LO : WORD_LO;
      CHECK_LO: if (transfer) next_state = CHECK_HI;
      CHECK_HI: if (transfer) begin
                  if (rx_word != checksum)  next_state = ERROR;
                  else if (RELEASE_DELAY == 0) next_state = RUN;
                  else                      next_state = RELEASE;
                end
      RELEASE:  if (release_last) next_state = RUN;
      RUN:      if (start) next_state = COUNT_LO;
      ERROR:    if (start) next_state = COUNT_LO;
      default:  next_state = COUNT_LO;
    endcase
  end

  always_comb begin
    byte_ready            = 1'b0;
    core_active_low_reset = 1'b0;
    load_done             = 1'b0;
    load_error            = 1'b0;
    unique case (state)
      COUNT_LO, COUNT_HI, WORD_LO, WORD_HI, CHECK_LO, CHECK_HI: byte_ready = 1'b1;
      RUN: begin
        core_active_low_reset = 1'b1;
        load_done             = 1'b1;
      end
      ERROR:   load_error = 1'b1;
      default: byte_ready = 1'b0;
    endcase
  end

  // Low bytes are parked in one register; every *_HI state pairs it with the incoming byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_byte   <= '0;
      word_count <= '0;
      word_index <= '0;
      checksum   <= '0;
    end else if (transfer) begin
      unique case (state)
        COUNT_LO, WORD_LO, CHECK_LO: low_byte <= byte_data;
        COUNT_HI: begin
          word_count <= rx_word[COUNT_WIDTH-1:0];
          word_index <= '0;
          checksum   <= '0;
        end
        WORD_HI: begin
          word_index <= word_index + 1'b1;
          checksum   <= checksum ^ rx_word;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction_write_enable  <= 1'b0;
      instruction_write_address <= '0;
      instruction_write_data    <= '0;
    end else begin
      instruction_write_enable <= transfer && (state == WORD_HI);
      if (transfer && (state == WORD_HI)) begin
        instruction_write_address <= word_index[ADDR_WIDTH-1:0];
        instruction_write_data    <= rx_word;
      end
    end
  end

  boot_loader_release_counter #(
    .CNT_WIDTH(16)
  ) u_release_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (release_load),
    .load_value (16'(RELEASE_DELAY)),
    .decrement  (state == RELEASE),
    .last       (release_last)
  );

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader: good loads, checksum and count
// errors, idle gaps, reload from RUN/ERROR and mid-load reset.
module tb_boot_loader;

  logic        clock;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        start;
  logic        instruction_write_enable;
  logic [12:0] instruction_write_address;
  logic [15:0] instruction_write_data;
  logic        core_active_low_reset;
  logic        load_done;
  logic        load_error;

  int vectors     = 0;
  int miscompares = 0;
  int write_count = 0;
  int write_base  = 0;

  boot_loader #(.RELEASE_DELAY(4)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .byte_valid                (byte_valid),
    .byte_data                 (byte_data),
    .byte_ready                (byte_ready),
    .start                     (start),
    .instruction_write_enable  (instruction_write_enable),
    .instruction_write_address (instruction_write_address),
    .instruction_write_data    (instruction_write_data),
    .core_active_low_reset     (core_active_low_reset),
    .load_done                 (load_done),
    .load_error                (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (instruction_write_enable === 1'b1) write_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int idle);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
    repeat (idle) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic checkWrite(input string tag, input logic [12:0] addr, input logic [15:0] data);
    checkOutput({tag, "_we"},   32'(instruction_write_enable), 32'd1);
    checkOutput({tag, "_addr"}, 32'(instruction_write_address), 32'(addr));
    checkOutput({tag, "_data"}, 32'(instruction_write_data), 32'(data));
  endtask

  task automatic checkRun(input string tag);
    checkOutput({tag, "_done"}, 32'(load_done), 32'd1);
    checkOutput({tag, "_core"}, 32'(core_active_low_reset), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    start      = 1'b0;
    #12;
    checkOutput("rst_ready", 32'(byte_ready), 32'd1);
    checkOutput("rst_we",    32'(instruction_write_enable), 32'd0);
    checkOutput("rst_addr",  32'(instruction_write_address), 32'd0);
    checkOutput("rst_data",  32'(instruction_write_data), 32'd0);
    checkOutput("rst_core",  32'(core_active_low_reset), 32'd0);
    checkOutput("rst_done",  32'(load_done), 32'd0);
    checkOutput("rst_err",   32'(load_error), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Good two-word load, contiguous bytes
    write_base = write_count;
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h80, 0);
    checkWrite("t1_w0", 13'd0, 16'h8001);
    applyStimulus(8'h00, 0);
    checkOutput("t1_strobe_drop", 32'(instruction_write_enable), 32'd0);
    applyStimulus(8'h60, 0);
    checkWrite("t1_w1", 13'd1, 16'h6000);
    applyStimulus(8'h01, 0);
    applyStimulus(8'hE0, 0);
    checkOutput("t1_rel_ready", 32'(byte_ready), 32'd0);
    checkOutput("t1_rel_core",  32'(core_active_low_reset), 32'd0);
    waitCycles(3);
    checkOutput("t1_rel3_done", 32'(load_done), 32'd0);
    waitCycles(1);
    checkRun("t1_run");
    checkOutput("t1_writes", 32'(write_count - write_base), 32'd2);

    // Reload from RUN
    write_base = write_count;
    pulseStart();
    checkOutput("t5_core_low", 32'(core_active_low_reset), 32'd0);
    checkOutput("t5_ready",    32'(byte_ready), 32'd1);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hCD, 0);
    applyStimulus(8'hAB, 0);
    checkWrite("t5_w0", 13'd0, 16'hABCD);
    applyStimulus(8'hCD, 0);
    applyStimulus(8'hAB, 0);
    waitCycles(4);
    checkRun("t5_run");
    checkOutput("t5_writes", 32'(write_count - write_base), 32'd1);

    // Bad checksum
    write_base = write_count;
    pulseStart();
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h80, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h60, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("t2_err",   32'(load_error), 32'd1);
    checkOutput("t2_core",  32'(core_active_low_reset), 32'd0);
    checkOutput("t2_ready", 32'(byte_ready), 32'd0);
    waitCycles(6);
    checkOutput("t2_err_hold", 32'(load_error), 32'd1);
    checkOutput("t2_done",     32'(load_done), 32'd0);
    checkOutput("t2_writes",   32'(write_count - write_base), 32'd2);

    // Count 8193 is rejected
    write_base = write_count;
    pulseStart();
    checkOutput("t3_err_clear", 32'(load_error), 32'd0);
    applyStimulus(8'h01, 0);
    checkOutput("t3_mid_err", 32'(load_error), 32'd0);
    applyStimulus(8'h20, 0);
    checkOutput("t3_err", 32'(load_error), 32'd1);
    waitCycles(2);
    checkOutput("t3_writes", 32'(write_count - write_base), 32'd0);

    // Count 0 is rejected
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("t0_err", 32'(load_error), 32'd1);

    // One word with idle gaps; start mid-load is ignored
    write_base = write_count;
    pulseStart();
    applyStimulus(8'h01, 0);
    pulseStart();
    waitCycles(2);
    checkOutput("t4_ready",  32'(byte_ready), 32'd1);
    checkOutput("t4_no_err", 32'(load_error), 32'd0);
    applyStimulus(8'h00, 3);
    applyStimulus(8'h34, 3);
    applyStimulus(8'h12, 0);
    checkWrite("t4_w0", 13'd0, 16'h1234);
    waitCycles(3);
    applyStimulus(8'h34, 3);
    applyStimulus(8'h12, 0);
    waitCycles(4);
    checkRun("t4_run");
    checkOutput("t4_writes", 32'(write_count - write_base), 32'd1);

    // Reset after the first word of a three-word load
    pulseStart();
    applyStimulus(8'h03, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    checkWrite("t6_w0", 13'd0, 16'h2211);
    reset = 1'b1;
    #1;
    checkOutput("t6_we",    32'(instruction_write_enable), 32'd0);
    checkOutput("t6_addr",  32'(instruction_write_address), 32'd0);
    checkOutput("t6_data",  32'(instruction_write_data), 32'd0);
    checkOutput("t6_core",  32'(core_active_low_reset), 32'd0);
    checkOutput("t6_done",  32'(load_done), 32'd0);
    checkOutput("t6_err",   32'(load_error), 32'd0);
    checkOutput("t6_ready", 32'(byte_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    write_base = write_count;
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h55, 0);
    applyStimulus(8'hAA, 0);
    checkWrite("t6_fresh_w0", 13'd0, 16'hAA55);
    applyStimulus(8'h55, 0);
    applyStimulus(8'hAA, 0);
    waitCycles(4);
    checkRun("t6_run");
    checkOutput("t6_writes", 32'(write_count - write_base), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter RELEASE_DELAY, default 4: clock cycles the core is held in reset after a good load.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 byte_valid  input  1  host byte stream: byte_data is valid.
REQ-005 byte_data  input  8  host byte payload.
REQ-006 byte_ready  output  1  loader accepts a byte; a transfer occurs when byte_valid and byte_ready are both high on a rising edge.
REQ-007 start  input  1  one-cycle reload request; honoured only in RUN or ERROR.
REQ-008 instruction_write_enable  output  1  one-cycle write strobe to instruction RAM.
REQ-009 instruction_write_address  output  13  instruction RAM word address.
REQ-010 instruction_write_data  output  16  instruction word.
REQ-011 core_active_low_reset  output  1  drives the core's active_low_reset; low holds the core.
REQ-012 load_done  output  1  high in RUN.
REQ-013 load_error  output  1  high in ERROR.

Function
REQ-014 Stream format, little-endian bytes: word count N (2 bytes), N instruction words (2 bytes each), checksum (2 bytes) = XOR of all N words.
REQ-015 States: COUNT_LO, COUNT_HI, WORD_LO, WORD_HI, CHECK_LO, CHECK_HI, RELEASE, RUN, ERROR; each *_LO/*_HI state advances on one accepted byte.
REQ-016 byte_ready high in COUNT_*, WORD_*, CHECK_*; low in RELEASE, RUN, ERROR.
REQ-017 COUNT_HI: N == 0 or N > 8192 -> ERROR; else -> WORD_LO with word index 0 and checksum 0.
REQ-018 WORD_HI accept: register word {high byte, low byte} and strobe instruction_write_enable for exactly the next cycle, address = word index, data = that word.
REQ-019 Word index increments after each write; the write of index N-1 -> CHECK_LO; otherwise -> WORD_LO.
REQ-020 Running checksum XORs each written word; CHECK_HI: received == running -> RELEASE, else -> ERROR.
REQ-021 RELEASE lasts exactly RELEASE_DELAY cycles, then -> RUN; RELEASE_DELAY = 0 goes directly to RUN.
REQ-022 core_active_low_reset low in every state except RUN; rises on the RUN entry edge.
REQ-023 start in RUN or ERROR -> COUNT_LO next cycle, core reset reasserted that same edge; start ignored in all other states.
REQ-024 Idle cycles (byte_valid low) between bytes are legal and do not change state or counters.
REQ-025 Address width is 13 bits; index 8191 is the last legal address, no wrap occurs because N <= 8192.
REQ-026 No write strobe is issued in any state other than the cycle after a WORD_HI accept; an ERROR entered mid-load leaves already-written words in RAM.

Reset
REQ-027 reset asserted: state COUNT_LO, byte_ready 1 after release, instruction_write_enable 0, address 0, data 0, core_active_low_reset 0, load_done 0, load_error 0, counters/checksum 0.
REQ-028 reset mid-load or in RUN aborts immediately; any pending write strobe is dropped.

Structure
REQ-029 State encoding and the maximum word count constant (8192) live in the shared package/header with WIDTH and DEPTH.
REQ-030 Single flat module; one sub-module natural: release_counter (loadable down-counter for RELEASE).

Verification
REQ-031 N=2, words 0x8001, 0x6000, checksum 0xE001, contiguous -> writes (0,0x8001),(1,0x6000); RUN after 4 RELEASE cycles; core_active_low_reset 1.
REQ-032 Same stream, checksum 0x0000 -> both writes occur, then ERROR, load_error 1, core_active_low_reset stays 0.
REQ-033 Count bytes 0x01,0x20 (N=8193) -> ERROR after second byte, no write strobe.
REQ-034 N=1, word 0x1234 with 3 idle cycles between every byte -> single write (0,0x1234), RUN reached.
REQ-035 In RUN, pulse start, resend N=1 word 0xABCD checksum 0xABCD -> core reset low next cycle, write (0,0xABCD), RUN again.
REQ-036 reset asserted after word 0 of an N=3 load -> all outputs at reset values; a fresh N=1 load then completes normally.
